serial_divisibility_checker: RTL and testbench



---
 rtl/serial_divisibility_checker.sv | 121 ++++++++++++
 tb/tb_serial_divisibility_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_divisibility_checker.sv
// Bit-serial divisibility checker: running residue of a serial number modulo DIVISOR, MSB- or LSB-first.
// Latency: one cycle from an accepted bit (in_valid) to out_valid/y (and rem when DIVCHK_REM_OUT_EN is defined).
// No backpressure: a bit is accepted on every cycle in_valid is high; idle gaps of any length hold state.
module serial_divisibility_checker #(
  parameter int DIVISOR   = 5,
  parameter int MSB_FIRST = 1,
  localparam int REM_W    = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             x,
  input  logic             clr,
  output logic             out_valid,
  output logic             y
`ifdef DIVCHK_REM_OUT_EN
  ,
  output logic [REM_W-1:0] rem
`endif
);

  // A modulus below 2 has no meaningful residue and would give a zero-width remainder.
  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("serial_divisibility_checker: DIVISOR must be >= 2");
    end
  endgenerate

  localparam logic [REM_W:0]   DIV_C = (REM_W+1)'(DIVISOR);
  localparam logic [REM_W-1:0] ONE_C = REM_W'(1);

  logic [REM_W-1:0] rem_q, rem_d;
  logic [REM_W-1:0] rem_base;   // remainder operand, forced to 0 when a new number starts
  logic [REM_W-1:0] rem_nxt;    // remainder after absorbing the current bit
  logic             y_q, y_d;
  logic             ov_q, ov_d;

  // clr together with in_valid makes the current bit the first bit of a fresh number.
  assign rem_base = clr ? '0 : rem_q;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      logic [REM_W:0] t;
      // Shift-in step: (2*rem + x) stays below 2*DIVISOR, so one conditional subtract reduces it.
      always_comb begin
        t       = {rem_base, 1'b0} + {{REM_W{1'b0}}, x};
        rem_nxt = (t >= DIV_C) ? REM_W'(t - DIV_C) : t[REM_W-1:0];
      end
    end else begin : g_lsb
      logic [REM_W-1:0] pw_q, pw_d;   // 2^k mod DIVISOR for the weight of the next bit
      logic [REM_W-1:0] pw_base;
      logic [REM_W:0]   s;
      logic [REM_W:0]   p2;
      logic [REM_W-1:0] pw_nxt;

      assign pw_base = clr ? ONE_C : pw_q;

      // Weighted add of the incoming bit and doubling of the weight, each reduced by one subtract.
      always_comb begin
        s       = {1'b0, rem_base} + (x ? {1'b0, pw_base} : '0);
        rem_nxt = (s >= DIV_C) ? REM_W'(s - DIV_C) : s[REM_W-1:0];
        p2      = {pw_base, 1'b0};
        pw_nxt  = (p2 >= DIV_C) ? REM_W'(p2 - DIV_C) : p2[REM_W-1:0];
      end

      // Weight next-state: advance on an accepted bit, restart on a bare clear, else hold.
      always_comb begin
        pw_d = pw_q;
        if (in_valid) begin
          pw_d = pw_nxt;
        end else if (clr) begin
          pw_d = ONE_C;
        end
      end

      // Weight register; an empty number's next bit has weight 1.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pw_q <= ONE_C;
        end else begin
          pw_q <= pw_d;
        end
      end
    end
  endgenerate

  // Output/remainder next-state: update on an accepted bit, reset to "empty number" on a bare clear.
  always_comb begin
    rem_d = rem_q;
    y_d   = y_q;
    ov_d  = 1'b0;
    if (in_valid) begin
      rem_d = rem_nxt;
      y_d   = (rem_nxt == '0);
      ov_d  = 1'b1;
    end else if (clr) begin
      rem_d = '0;
      y_d   = 1'b1;
    end
  end

  // State registers; the empty number (value 0) counts as divisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      y_q   <= 1'b1;
      ov_q  <= 1'b0;
    end else begin
      rem_q <= rem_d;
      y_q   <= y_d;
      ov_q  <= ov_d;
    end
  end

  assign out_valid = ov_q;
  assign y         = y_q;
`ifdef DIVCHK_REM_OUT_EN
  assign rem       = rem_q;
`endif

endmodule

// File: tb/tb_serial_divisibility_checker.sv
// Directed bench for serial_divisibility_checker: three instances (mod 5 MSB-first, mod 3 LSB-first, mod 7 MSB-first).
// All instances see the same input stream; each check targets the instance whose scenario is being exercised.
// Remainder checks are compiled in only when DIVCHK_REM_OUT_EN is defined.
module tb_serial_divisibility_checker;

  logic clk;
  logic rst;
  logic in_valid;
  logic x;
  logic clr;

  logic ov_a [3];
  logic y_a  [3];
  logic [2:0] r5;
  logic [1:0] r3;
  logic [2:0] r7;

  int n_tests;
  int n_fail;

  typedef struct {
    string name;
    int    dut;    // 0: mod 5 MSB, 1: mod 3 LSB, 2: mod 7 MSB
    logic  iv;
    logic  xb;
    logic  c;
    logic  e_ov;
    logic  e_y;
    int    e_rem;
  } vec_t;

  vec_t tbl[$];

  serial_divisibility_checker #(.DIVISOR(5), .MSB_FIRST(1)) u_d5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clr(clr),
    .out_valid(ov_a[0]), .y(y_a[0])
`ifdef DIVCHK_REM_OUT_EN
    , .rem(r5)
`endif
  );

  serial_divisibility_checker #(.DIVISOR(3), .MSB_FIRST(0)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clr(clr),
    .out_valid(ov_a[1]), .y(y_a[1])
`ifdef DIVCHK_REM_OUT_EN
    , .rem(r3)
`endif
  );

  serial_divisibility_checker #(.DIVISOR(7), .MSB_FIRST(1)) u_d7 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .clr(clr),
    .out_valid(ov_a[2]), .y(y_a[2])
`ifdef DIVCHK_REM_OUT_EN
    , .rem(r7)
`endif
  );

`ifndef DIVCHK_REM_OUT_EN
  assign r5 = '0;
  assign r3 = '0;
  assign r7 = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rem_of(int d);
    case (d)
      0:       return int'(r5);
      1:       return int'(r3);
      default: return int'(r7);
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string name, int d, logic e_ov, logic e_y, int e_rem);
    chk({name, ".out_valid"}, int'(ov_a[d]), int'(e_ov));
    chk({name, ".y"}, int'(y_a[d]), int'(e_y));
`ifdef DIVCHK_REM_OUT_EN
    chk({name, ".rem"}, rem_of(d), e_rem);
`endif
  endtask

  // Drive one cycle of inputs and sample 1 time unit after the rising edge.
  task automatic step(logic iv, logic xb, logic c);
    in_valid = iv;
    x        = xb;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(string n, int d, logic iv, logic xb, logic c,
                              logic e_ov, logic e_y, int e_rem);
    vec_t v;
    v.name = n; v.dut = d; v.iv = iv; v.xb = xb; v.c = c;
    v.e_ov = e_ov; v.e_y = e_y; v.e_rem = e_rem;
    tbl.push_back(v);
  endfunction

  initial begin
    int ov_cnt;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    x        = 1'b0;
    clr      = 1'b0;

    // Reset state on every instance.
    #2;
    for (int d = 0; d < 3; d++) chk_all($sformatf("reset%0d", d), d, 1'b0, 1'b1, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // mod 5 MSB-first: 1,0,1,0 -> values 1,2,5,10
    add("d5_clr",  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    add("d5_b0",   0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    add("d5_b1",   0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    add("d5_b2",   0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    add("d5_b3",   0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    // mod 3 LSB-first: 0,1,1 -> values 0,2,6
    add("d3_clr",  1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    add("d3_b0",   1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    add("d3_b1",   1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    add("d3_b2",   1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    // mod 7 MSB-first: six ones -> 1,3,7,15,31,63; first bit also restarts via clr
    add("d7_b0",   2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    add("d7_b1",   2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    add("d7_b2",   2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    add("d7_b3",   2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    add("d7_b4",   2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    add("d7_b5",   2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    add("d7_idle", 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].xb, tbl[i].c);
      chk_all(tbl[i].name, tbl[i].dut, tbl[i].e_ov, tbl[i].e_y, tbl[i].e_rem);
    end

    // mod 5 with 3 idle cycles after each bit (x toggling while idle must be ignored).
    step(1'b0, 1'b0, 1'b1);
    ov_cnt = 0;
    step(1'b1, 1'b1, 1'b0); ov_cnt += int'(ov_a[0]);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, g[0], 1'b0); ov_cnt += int'(ov_a[0]);
      chk_all($sformatf("gap_a%0d", g), 0, 1'b0, 1'b0, 1);
    end
    step(1'b1, 1'b0, 1'b0); ov_cnt += int'(ov_a[0]);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, ~g[0], 1'b0); ov_cnt += int'(ov_a[0]);
      chk_all($sformatf("gap_b%0d", g), 0, 1'b0, 1'b0, 2);
    end
    step(1'b1, 1'b1, 1'b0); ov_cnt += int'(ov_a[0]);
    chk_all("gap_final", 0, 1'b1, 1'b1, 0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b1, 1'b0); ov_cnt += int'(ov_a[0]);
    end
    chk("gap_pulses", ov_cnt, 3);
    chk("gap_hold_y", int'(y_a[0]), 1);

    // Clear mid-stream: build rem=2, then clr with a bit, then clr alone.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_all("clr_pre", 0, 1'b1, 1'b0, 2);
    step(1'b1, 1'b1, 1'b1);
    chk_all("clr_bit", 0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1'b1);
    chk_all("clr_only", 0, 1'b0, 1'b1, 0);

    // Asynchronous reset between clock edges while out_valid is high.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk_all("rst_pre", 0, 1'b1, 1'b0, 3);
    #3;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 0, 1'b0, 1'b1, 0);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    chk_all("rst_after", 0, 1'b1, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
